pong_paddle_adc: RTL and testbench

- Upstream feeder of the right-paddle analog input port.
- Periodically reads a potentiometer through a 3-wire serial 8-bit ADC, then applies a moving-average filter and hysteresis.
- Presents a stable 8-bit paddle position that wires directly to the PIO in_port. It sits at the board-pin boundary, outside the Avalon fabric.

---
 rtl/pong_adc_pkg.sv | 26 ++
 rtl/pong_adc_avg.sv | 52 +++++
 rtl/pong_paddle_adc.sv | 156 +++++++++++++++
 tb/tb_pong_paddle_adc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_adc_pkg.sv
// Shared types and constants for the paddle ADC reader: FSM states,
// serial frame layout and the paddle reset position.
package pong_adc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    STOP   = 3'd3,
    FILTER = 3'd4
  } state_t;

  localparam int FRAME_BITS     = 16;
  localparam int DATA_FIRST_BIT = 8;

  localparam int START_BIT = 0;
  localparam int SGL_BIT   = 1;
  localparam int CH_BIT    = 2;

  localparam logic [7:0] POS_RESET = 8'h80;

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pong_adc_avg.sv
// Moving-average filter with hysteresis; turns raw ADC samples into a
// stable paddle position plus a change pulse.
module pong_adc_avg
  import pong_adc_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic [7:0] paddle_pos,
  output logic       pos_update
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 8 + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [7:0]       avg_buf [DEPTH];
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] new_sum;
  logic [IDX_W-1:0] idx;
  logic [7:0]       avg;
  logic             take;

  // Modular arithmetic: the intermediate may wrap but the result always fits.
  assign new_sum = sum - SUM_W'(avg_buf[idx]) + SUM_W'(sample);
  assign avg     = 8'(new_sum >> AVG_LOG2);
  assign take    = (int'(abs_diff8(avg, paddle_pos)) >= HYST) ||
                   (avg == 8'h00) || (avg == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) avg_buf[i] <= POS_RESET;
      sum        <= SUM_W'(POS_RESET) << AVG_LOG2;
      idx        <= '0;
      paddle_pos <= POS_RESET;
      pos_update <= 1'b0;
    end else if (sample_valid) begin
      sum          <= new_sum;
      avg_buf[idx] <= sample;
      idx          <= (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
      if (take) paddle_pos <= avg;
      pos_update   <= take && (avg != paddle_pos);
    end else begin
      pos_update <= 1'b0;
    end
  end

endmodule

// File: rtl/pong_paddle_adc.sv
// Periodic 3-wire serial ADC reader for the right paddle potentiometer;
// feeds the filtered position straight to the PIO in_port.
module pong_paddle_adc
  import pong_adc_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int CHANNEL       = 0,
  parameter int AVG_LOG2      = 2,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout,
  output logic [7:0] paddle_pos,
  output logic       pos_update,
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [FRAME_BITS-1:0] CMD =
    FRAME_BITS'((1 << START_BIT) | (1 << SGL_BIT) | ((CHANNEL & 1) << CH_BIT));

  state_t           state, nxt_state;
  logic [DIV_W-1:0] div_cnt, nxt_div;
  logic [3:0]       bit_cnt, nxt_bit;
  logic             half, nxt_half;
  logic             frame_go;
  logic             div_last;
  logic [TMR_W-1:0] tmr;
  logic             pending;
  logic [1:0]       dout_sync;
  logic [7:0]       sample;

  assign div_last = (div_cnt == DIV_LAST);

  always_comb begin
    nxt_state = state;
    nxt_div   = div_cnt;
    nxt_half  = half;
    nxt_bit   = bit_cnt;
    frame_go  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending && enable) begin
          nxt_state = SETUP;
          nxt_div   = '0;
          frame_go  = 1'b1;
        end
      end
      SETUP: begin
        if (div_last) begin
          nxt_state = SHIFT;
          nxt_div   = '0;
          nxt_half  = 1'b0;
          nxt_bit   = '0;
        end else nxt_div = div_cnt + 1'b1;
      end
      SHIFT: begin
        if (div_last) begin
          nxt_div  = '0;
          nxt_half = ~half;
          if (half) begin
            nxt_bit = bit_cnt + 4'd1;
            if (bit_cnt == 4'(FRAME_BITS - 1)) nxt_state = STOP;
          end
        end else nxt_div = div_cnt + 1'b1;
      end
      STOP: begin
        if (div_last) begin
          nxt_state = FILTER;
          nxt_div   = '0;
        end else nxt_div = div_cnt + 1'b1;
      end
      FILTER: begin
        // A frame that came due mid-frame starts without an IDLE gap.
        if (pending && enable) begin
          nxt_state = SETUP;
          frame_go  = 1'b1;
        end else nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr     <= '0;
      pending <= 1'b0;
    end else if (!enable) begin
      tmr     <= '0;
      pending <= 1'b0;
    end else if (tmr == TMR_LAST) begin
      tmr     <= '0;
      pending <= 1'b1;
    end else begin
      tmr <= tmr + 1'b1;
      if (frame_go) pending <= 1'b0;
    end
  end

  // Pin outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      half     <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      adc_din  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt_state;
      div_cnt  <= nxt_div;
      bit_cnt  <= nxt_bit;
      half     <= nxt_half;
      adc_cs_n <= !((nxt_state == SETUP) || (nxt_state == SHIFT));
      adc_sclk <= (nxt_state == SHIFT) && nxt_half;
      adc_din  <= (nxt_state == SETUP) ? CMD[START_BIT] :
                  (nxt_state == SHIFT) ? CMD[nxt_bit] : 1'b0;
      busy     <= (nxt_state != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_sync <= '0;
      sample    <= '0;
    end else begin
      dout_sync <= {dout_sync[0], adc_dout};
      if ((state == SHIFT) && half && div_last && (bit_cnt >= 4'(DATA_FIRST_BIT)))
        sample <= {sample[6:0], dout_sync[1]};
    end
  end

  pong_adc_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .HYST     (HYST)
  ) u_avg (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_valid (state == FILTER),
    .paddle_pos   (paddle_pos),
    .pos_update   (pos_update)
  );

endmodule

// File: tb/tb_pong_paddle_adc.sv
// Scoreboard bench for pong_paddle_adc: two instances (direct/hysteresis and
// averaging) share one ADC model; frame results are checked by a monitor.
module tb_pong_paddle_adc;

  localparam int CLK_DIV = 4;
  localparam int SP      = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable_a = 1'b0;
  logic enable_b = 1'b0;
  logic adc_dout = 1'b0;

  logic       cs_a, sclk_a, din_a, upd_a, busy_a;
  logic       cs_b, sclk_b, din_b, upd_b, busy_b;
  logic [7:0] pos_a, pos_b;

  always #5 clk = ~clk;

  pong_paddle_adc #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .CHANNEL(1),
                    .AVG_LOG2(0), .HYST(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable_a),
    .adc_cs_n(cs_a), .adc_sclk(sclk_a), .adc_din(din_a), .adc_dout(adc_dout),
    .paddle_pos(pos_a), .pos_update(upd_a), .busy(busy_a));

  pong_paddle_adc #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP), .CHANNEL(0),
                    .AVG_LOG2(2), .HYST(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_b),
    .adc_cs_n(cs_b), .adc_sclk(sclk_b), .adc_din(din_b), .adc_dout(adc_dout),
    .paddle_pos(pos_b), .pos_update(upd_b), .busy(busy_b));

  int checks = 0;
  int failures = 0;
  logic sel = 1'b0;
  logic [7:0] adc_q [$];
  logic [8:0] exp_q [$];
  int exp_pulses_a = 0, exp_pulses_b = 0, pulses_a = 0, pulses_b = 0;

  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
  int fcnt = 0, rises = 0, busy_run = 0, last_run = 0, gap = 0;
  int frames_started = 0, cs_falls = 0, end_cnt = 0;
  logic [15:0] din_bits = '0;
  logic [7:0] cur_val = '0;
  int gaps [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ADC model, frame measurements and scoreboard monitor.
  always @(negedge clk) begin
    logic cs, sk, bz;
    logic [8:0] e;
    cs = cs_a & cs_b;
    sk = sclk_a | sclk_b;
    bz = busy_a | busy_b;
    if (!reset_n) begin
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_busy = 1'b0;
      end_cnt = 0; busy_run = 0; gap = 0; adc_dout = 1'b0;
    end else begin
      if (upd_a) pulses_a++;
      if (upd_b) pulses_b++;
      if (prev_cs && !cs) begin
        cur_val = (adc_q.size() > 0) ? adc_q.pop_front() : 8'h00;
        fcnt = 0; rises = 0; din_bits = '0; cs_falls++;
        if (bz && gap > 0) gaps.push_back(gap);
        gap = 0;
      end
      if (cs) adc_dout = 1'b0;
      else if (prev_sclk && !sk) begin
        fcnt++;
        if (fcnt >= 8 && fcnt <= 15) adc_dout = cur_val[15 - fcnt];
        else adc_dout = 1'b0;
      end
      if (!prev_sclk && sk) begin
        if (rises < 16) din_bits[rises] = din_a | din_b;
        rises++;
      end
      if (bz) busy_run++;
      else if (prev_busy) begin last_run = busy_run; busy_run = 0; end
      if (!prev_busy && bz) frames_started++;
      if (!bz) gap = 0;
      else if (cs) gap++;
      if (!prev_cs && cs) end_cnt = CLK_DIV + 1;
      else if (end_cnt > 0) begin
        end_cnt--;
        if (end_cnt == 0) begin
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("paddle_pos", sel ? pos_b : pos_a, e[7:0]);
            check("pos_update", sel ? upd_b : upd_a, e[8]);
          end
        end
      end
      prev_cs = cs; prev_sclk = sk; prev_busy = bz;
    end
  end

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (((sel ? busy_b : busy_a) !== val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1);
  endtask

  task automatic run_frame(input logic [7:0] val, input logic [7:0] exp_pos, input logic exp_upd);
    adc_q.push_back(val);
    exp_q.push_back({exp_upd, exp_pos});
    if (sel) begin exp_pulses_b += int'(exp_upd); enable_b = 1'b1; end
    else begin exp_pulses_a += int'(exp_upd); enable_a = 1'b1; end
    wait_busy(1'b1, SP + 20, "frame_start_timeout");
    enable_a = 1'b0;
    enable_b = 1'b0;
    wait_busy(1'b0, 200, "frame_end_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, n0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_cs_n", cs_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_din", din_a, 0);
    check("rst_pos", pos_a, 8'h80);
    check("rst_upd", upd_a, 0);
    check("rst_busy", busy_a, 0);

    // Single frame, channel 1, sample C4.
    run_frame(8'hC4, 8'hC4, 1'b1);
    check("sclk_rises", rises, 16);
    check("din_seq", din_bits, 16'h0007);
    check("frame_len", last_run, 137);

    // Asynchronous reset in the middle of SHIFT.
    enable_a = 1'b1;
    wait_busy(1'b1, SP + 20, "abort_start_timeout");
    n = 0;
    while (sclk_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("abort_sclk_timeout", n < 100, 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_cs_n", cs_a, 1);
    check("async_sclk", sclk_a, 0);
    check("async_pos", pos_a, 8'h80);
    check("async_busy", busy_a, 0);
    enable_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n0 = frames_started;
    repeat (3 * SP) @(negedge clk);
    check("idle_no_frames", frames_started, n0);
    check("idle_busy", busy_a, 0);

    // Hysteresis on instance A (HYST=2, no averaging).
    run_frame(8'h40, 8'h40, 1'b1);
    run_frame(8'h41, 8'h40, 1'b0);
    run_frame(8'h42, 8'h42, 1'b1);
    run_frame(8'hFE, 8'hFE, 1'b1);
    run_frame(8'hFF, 8'hFF, 1'b1);
    run_frame(8'h00, 8'h00, 1'b1);
    run_frame(8'h01, 8'h00, 1'b0);

    // Back-to-back frames: sample period shorter than a frame.
    adc_q.push_back(8'h50); exp_q.push_back({1'b1, 8'h50});
    adc_q.push_back(8'h90); exp_q.push_back({1'b1, 8'h90});
    adc_q.push_back(8'h10); exp_q.push_back({1'b1, 8'h10});
    exp_pulses_a += 3;
    gaps.delete();
    n0 = cs_falls;
    enable_a = 1'b1;
    n = 0;
    while (cs_falls < n0 + 3 && n < 600) begin @(negedge clk); n++; end
    check("b2b_start_timeout", n < 600, 1);
    enable_a = 1'b0;
    wait_busy(1'b0, 200, "b2b_end_timeout");
    repeat (3) @(negedge clk);
    check("b2b_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check("b2b_gap0", gaps[0], CLK_DIV + 1);
      check("b2b_gap1", gaps[1], CLK_DIV + 1);
    end
    n0 = cs_falls;
    repeat (3 * SP) @(negedge clk);
    check("b2b_no_more_frames", cs_falls, n0);

    // Averaging on instance B (depth 4, HYST=0).
    sel = 1'b1;
    run_frame(8'h80, 8'h80, 1'b0);
    run_frame(8'h80, 8'h80, 1'b0);
    run_frame(8'h80, 8'h80, 1'b0);
    run_frame(8'hFF, 8'h9F, 1'b1);
    run_frame(8'h80, 8'h9F, 1'b0);
    run_frame(8'h00, 8'h7F, 1'b1);

    check("pulses_a", pulses_a, exp_pulses_a);
    check("pulses_b", pulses_b, exp_pulses_b);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
